// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and the bus initiator state type, shared by the master and its address generator.
// Holds HTRANS/HBURST/HSIZE codes, the FSM state enum and a burst-code selection helper.
// No ports; imported by ahb_addr_gen and ahb_lite_master.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {IDLE, ADDR, PIPE, LAST, ERR} master_state_t;

  // Wrapping bursts exist only for 4/8/16 beats; anything else multi-beat is INCR.
  function automatic logic [2:0] pick_burst(input int unsigned beats, input logic wrap);
    logic [2:0] code;
    code = HBURST_INCR;
    if (beats == 1)
      code = HBURST_SINGLE;
    else if (wrap && beats == 4)
      code = HBURST_WRAP4;
    else if (wrap && beats == 8)
      code = HBURST_WRAP8;
    else if (wrap && beats == 16)
      code = HBURST_WRAP16;
    return code;
  endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Combinational next-beat address for an AHB burst.
// Ports: addr/hsize/hburst in; next_addr (addr + 1<<hsize, wrapped inside the
// burst block for WRAPx) and crosses_1k (INCR step leaves the current 1KB page) out.
module ahb_addr_gen
  import ahb_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  output logic [31:0] next_addr,
  output logic        crosses_1k
);

  logic [31:0] step;
  logic [31:0] incr;
  logic [31:0] wrap_bytes;
  logic [31:0] wrap_mask;
  logic        is_wrap;

  always_comb begin
    step       = 32'd1 << hsize;
    incr       = addr + step;
    is_wrap    = 1'b1;
    wrap_bytes = 32'd0;
    case (hburst)
      HBURST_WRAP4:  wrap_bytes = 32'd4 << hsize;
      HBURST_WRAP8:  wrap_bytes = 32'd8 << hsize;
      HBURST_WRAP16: wrap_bytes = 32'd16 << hsize;
      default:       is_wrap = 1'b0;
    endcase
    wrap_mask = wrap_bytes - 32'd1;

    if (is_wrap) begin
      // Upper bits stay fixed, low bits roll over within the aligned block;
      // a wrap block never spans a 1KB page so no restart is needed.
      next_addr  = (addr & ~wrap_mask) | (incr & wrap_mask);
      crosses_1k = 1'b0;
    end else begin
      next_addr  = incr;
      crosses_1k = (incr[31:10] != addr[31:10]);
    end
  end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite bus initiator: takes one single/multi-beat request from a local client and runs it on the bus.
// Ports: clk/n_rst; client side req*/req_ack/busy/done/err, wdata/wdata_ack, rdata/rdata_valid;
// bus side haddr/htrans/hwrite/hsize/hburst/hwdata out, hrdata/hready/hresp in. Macro AHB_MASTER_WRAP_EN adds req_wrap (WRAP4/8/16).
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter  int MAX_BEATS = 16,
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
`ifdef AHB_MASTER_WRAP_EN
  input  logic              req_wrap,
`endif
  input  logic              req,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [2:0]        req_size,
  input  logic [BEAT_W-1:0] req_beats,
  output logic              req_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [31:0]       wdata,
  output logic              wdata_ack,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic [31:0]       haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [31:0]       hwdata,
  input  logic [31:0]       hrdata,
  input  logic              hready,
  input  logic              hresp
);

  master_state_t     state;
  logic [BEAT_W-1:0] addr_left;
  logic [BEAT_W-1:0] data_left;
  logic [1:0]        htrans_q;
  logic [BEAT_W-1:0] beats_eff;
  logic              wrap_sel;
  logic [31:0]       next_addr;
  logic              crosses_1k;
  logic              data_phase;
  logic              err_first;

  function automatic logic [BEAT_W-1:0] sat_dec(input logic [BEAT_W-1:0] v);
    return (v == '0) ? v : v - BEAT_W'(1);
  endfunction

`ifdef AHB_MASTER_WRAP_EN
  assign wrap_sel = req_wrap;
`else
  assign wrap_sel = 1'b0;
`endif

  assign beats_eff  = (req_beats == '0) ? BEAT_W'(1) : req_beats;
  assign data_phase = (state == PIPE) || (state == LAST);
  assign err_first  = data_phase && hresp && !hready;

  // The pending address is cancelled in the very first ERROR cycle, before
  // the registered IDLE takes over in the second cycle.
  assign htrans    = err_first ? HTRANS_IDLE : htrans_q;
  assign wdata_ack = data_phase && hready && hwrite;
  assign hwdata    = (data_phase && hwrite) ? wdata : 32'd0;
  assign done      = hready && ((state == LAST) || (state == ERR));
  assign err       = hready && (state == ERR);

  ahb_addr_gen u_addr_gen (
    .addr       (haddr),
    .hsize      (hsize),
    .hburst     (hburst),
    .next_addr  (next_addr),
    .crosses_1k (crosses_1k)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      addr_left   <= '0;
      data_left   <= '0;
      haddr       <= 32'd0;
      htrans_q    <= HTRANS_IDLE;
      hwrite      <= 1'b0;
      hsize       <= HSIZE_BYTE;
      hburst      <= HBURST_SINGLE;
      req_ack     <= 1'b0;
      busy        <= 1'b0;
      rdata       <= 32'd0;
      rdata_valid <= 1'b0;
    end else begin
      req_ack     <= 1'b0;
      rdata_valid <= 1'b0;

      if (data_phase && hready && !hresp && !hwrite) begin
        rdata       <= hrdata;
        rdata_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (req) begin
            addr_left <= beats_eff;
            data_left <= beats_eff;
            haddr     <= req_addr;
            htrans_q  <= HTRANS_NONSEQ;
            hwrite    <= req_write;
            hsize     <= req_size;
            hburst    <= pick_burst(32'(beats_eff), wrap_sel);
            req_ack   <= 1'b1;
            busy      <= 1'b1;
            state     <= ADDR;
          end
        end

        ADDR: begin
          if (hready) begin
            addr_left <= sat_dec(addr_left);
            if (addr_left == BEAT_W'(1)) begin
              htrans_q <= HTRANS_IDLE;
              state    <= LAST;
            end else begin
              haddr    <= next_addr;
              htrans_q <= crosses_1k ? HTRANS_NONSEQ : HTRANS_SEQ;
              state    <= PIPE;
            end
          end
        end

        PIPE: begin
          if (err_first) begin
            htrans_q <= HTRANS_IDLE;
            state    <= ERR;
          end else if (hready) begin
            addr_left <= sat_dec(addr_left);
            data_left <= sat_dec(data_left);
            if (addr_left == BEAT_W'(1)) begin
              htrans_q <= HTRANS_IDLE;
              state    <= LAST;
            end else begin
              haddr    <= next_addr;
              htrans_q <= crosses_1k ? HTRANS_NONSEQ : HTRANS_SEQ;
            end
          end
        end

        LAST: begin
          if (err_first) begin
            htrans_q <= HTRANS_IDLE;
            state    <= ERR;
          end else if (hready) begin
            data_left <= sat_dec(data_left);
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        ERR: begin
          if (hready) begin
            addr_left <= '0;
            data_left <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
